// File: rtl/alu_wide_seq_if.sv
// Bus bundle for alu_wide_seq: request/result side plus the
// byte-wide ALU drive/return side.
interface alu_wide_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic [2:0]  alu_cmd;
  logic [7:0]  alu_inA;
  logic [7:0]  alu_inB;
  logic        alu_sc_i;
  logic [7:0]  alu_rslt;
  logic        alu_sc_o;

  modport slave (
    input  start, op, a, b,
    input  alu_rslt, alu_sc_o,
    output busy, done, result, carry, zero,
    output alu_cmd, alu_inA, alu_inB, alu_sc_i
  );

  modport master (
    output start, op, a, b,
    output alu_rslt, alu_sc_o,
    input  busy, done, result, carry, zero,
    input  alu_cmd, alu_inA, alu_inB, alu_sc_i
  );
endinterface

// File: rtl/alu_wide_seq.sv
// 16-bit ADD/SUB/AND/XOR sequenced as two passes through an
// external 8-bit ALU (low byte, then high byte with carry chain).
module alu_wide_seq (
  input  logic      clk,
  input  logic      rst_n,
  alu_wide_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, LO, HI, DONE
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  lo_q, lo_d;
  logic        c_lo_q, c_lo_d;
  logic [15:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        arith;
  logic        sel_hi;
  logic [7:0]  byte_a, byte_b;

  assign arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign sel_hi = (state_q == HI);
  assign byte_a = sel_hi ? a_q[15:8] : a_q[7:0];
  assign byte_b = sel_hi ? b_q[15:8] : b_q[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result register's upper byte doubles as the HI-byte capture.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    lo_d    = lo_q;
    c_lo_d  = c_lo_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (state_q == IDLE && bus.start) begin
      a_d  = bus.a;
      b_d  = bus.b;
      op_d = bus.op;
    end
    if (state_q == LO) begin
      lo_d   = bus.alu_rslt;
      c_lo_d = bus.alu_sc_o;
    end
    if (state_q == HI) begin
      res_d   = {bus.alu_rslt, lo_q};
      carry_d = arith & bus.alu_sc_o;
      zero_d  = (res_d == 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      lo_q    <= '0;
      c_lo_q  <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      c_lo_q  <= c_lo_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // SUB runs as A + ~B + 1 on the ALU's add command.
  always_comb begin
    bus.alu_cmd  = 3'b000;
    bus.alu_inA  = 8'h00;
    bus.alu_inB  = 8'h00;
    bus.alu_sc_i = 1'b0;
    bus.busy     = (state_q != IDLE);
    bus.done     = (state_q == DONE);
    if (state_q == LO || state_q == HI) begin
      bus.alu_inA = byte_a;
      unique case (1'b1)
        op_q == OP_AND: begin
          bus.alu_cmd = 3'b010;
          bus.alu_inB = byte_b;
        end
        op_q == OP_XOR: begin
          bus.alu_cmd = 3'b011;
          bus.alu_inB = byte_b;
        end
        op_q == OP_SUB: begin
          bus.alu_inB  = ~byte_b;
          bus.alu_sc_i = sel_hi ? c_lo_q : 1'b1;
        end
        default: begin
          bus.alu_inB  = byte_b;
          bus.alu_sc_i = sel_hi ? c_lo_q : 1'b0;
        end
      endcase
    end
  end

  assign bus.result = res_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: 8-bit ALU model on the alu_* side,
// scoreboard queue of expected results, directed plus random ops.
module tb_alu_wide_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_wide_seq_if bus ();

  alu_wide_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [8:0] alu_s;
  always_comb begin
    alu_s = '0;
    case (bus.alu_cmd)
      3'b000: alu_s = {1'b0, bus.alu_inA} + {1'b0, bus.alu_inB}
                      + {8'd0, bus.alu_sc_i};
      3'b001: alu_s = {1'b0, bus.alu_inA} + {1'b0, ~bus.alu_inB}
                      + {8'd0, bus.alu_sc_i};
      3'b010: alu_s = {1'b0, bus.alu_inA & bus.alu_inB};
      3'b011: alu_s = {1'b0, bus.alu_inA ^ bus.alu_inB};
      default: alu_s = {1'b0, bus.alu_inA | bus.alu_inB};
    endcase
    bus.alu_rslt = alu_s[7:0];
    bus.alu_sc_o = alu_s[8];
  end

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        z;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  function automatic exp_t ref_op(input logic [1:0] op,
                                  input logic [15:0] a, b);
    exp_t e;
    int s;
    e.c = 1'b0;
    case (op)
      2'd0: begin
        s = int'(a) + int'(b);
        e.r = s[15:0];
        e.c = (s > 65535);
      end
      2'd1: begin
        e.r = a - b;
        e.c = (a >= b);
      end
      2'd2: e.r = a & b;
      default: e.r = a ^ b;
    endcase
    e.z = (e.r == 16'h0000);
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done result=%h", bus.result);
      end else begin
        mon_e = q.pop_front();
        chk("result", bus.result, mon_e.r);
        chk("carry", bus.carry, mon_e.c);
        chk("zero", bus.zero, mon_e.z);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input bit repulse,
                        input logic [15:0] a2, input logic [15:0] b2);
    logic [7:0] alo, ahi, blo, bhi;
    logic [2:0] cmd;
    logic       lc, lsc, hsc;
    alo = a[7:0];
    ahi = a[15:8];
    blo = (op == 2'd1) ? ~b[7:0] : b[7:0];
    bhi = (op == 2'd1) ? ~b[15:8] : b[15:8];
    cmd = (op == 2'd2) ? 3'b010 : (op == 2'd3) ? 3'b011 : 3'b000;
    if (op == 2'd0) lc = (int'(a[7:0]) + int'(b[7:0])) > 255;
    else            lc = (a[7:0] >= b[7:0]);
    lsc = (op == 2'd1);
    hsc = (op < 2'd2) ? lc : 1'b0;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    q.push_back(ref_op(op, a, b));
    #1;
    if (repulse) begin
      bus.a = a2;
      bus.b = b2;
      bus.op = 2'($urandom_range(0, 3));
    end else begin
      bus.start = 1'b0;
    end
    @(negedge clk);
    chk("lo_busy", bus.busy, 1);
    chk("lo_done", bus.done, 0);
    chk("lo_cmd", bus.alu_cmd, cmd);
    chk("lo_inA", bus.alu_inA, alo);
    chk("lo_inB", bus.alu_inB, blo);
    chk("lo_sci", bus.alu_sc_i, lsc);
    @(negedge clk);
    chk("hi_done", bus.done, 0);
    chk("hi_cmd", bus.alu_cmd, cmd);
    chk("hi_inA", bus.alu_inA, ahi);
    chk("hi_inB", bus.alu_inB, bhi);
    chk("hi_sci", bus.alu_sc_i, hsc);
    bus.start = 1'b0;
    @(negedge clk);
    chk("dn_done", bus.done, 1);
    chk("dn_busy", bus.busy, 1);
    chk("dn_cmd", bus.alu_cmd, 0);
    chk("dn_inA", bus.alu_inA, 0);
    @(posedge clk);
    #1;
  endtask

  int dc;

  initial begin
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a = 16'h1234;
    bus.b = 16'h0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_carry", bus.carry, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_cmd", bus.alu_cmd, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_start_ign", bus.busy, 0);
    @(posedge clk);
    #1;

    run_op(2'd0, 16'h00FF, 16'h0001, 0, 0, 0);
    run_op(2'd0, 16'hFFFF, 16'h0001, 0, 0, 0);
    run_op(2'd1, 16'h1000, 16'h0001, 0, 0, 0);
    run_op(2'd1, 16'h0000, 16'h0001, 0, 0, 0);
    run_op(2'd3, 16'hA5A5, 16'hFFFF, 0, 0, 0);
    dc = done_cnt;
    run_op(2'd0, 16'h0001, 16'h0002, 1, 16'h1111, 16'h2222);
    repeat (4) @(posedge clk);
    #1;
    chk("one_done", done_cnt, dc + 1);

    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a = 16'h4321;
    bus.b = 16'h1111;
    @(posedge clk);
    q.push_back(ref_op(2'd0, 16'h4321, 16'h1111));
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    void'(q.pop_back());
    dc = done_cnt;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_zero", bus.zero, 1);
    chk("abort_carry", bus.carry, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_nodone", done_cnt, dc);
    run_op(2'd0, 16'h1234, 16'h4321, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
